stats_window: RTL and testbench

//  Windowed signal statistics stage that sits directly downstream of the registered 8:1 signal muxer.
//  It takes the selected signed RES-bit signal and accumulates 2^n gated samples.
//  At the end of each window it reports the mean, minimum and maximum.

---
 rtl/stats_window.sv | 115 +++++++++++
 tb/tb_stats_window.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stats_window.sv
// rtl/stats_window.sv - windowed mean/min/max of a signed sample stream
// Accumulates 2^n gated samples per window, one-shot or back-to-back.
module stats_window #(
  parameter int RES       = 14,
  parameter int LOG2N_MAX = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [RES-1:0] in_dat,
  input  logic                  in_en,
  input  logic                  start,
  input  logic                  cont,
  input  logic [3:0]            log2n,
  output logic signed [RES-1:0] mean,
  output logic signed [RES-1:0] min,
  output logic signed [RES-1:0] max,
  output logic                  valid,
  output logic                  busy
);

  localparam int AW = RES + LOG2N_MAX;
  localparam int CW = LOG2N_MAX;
  localparam logic [3:0]  NMAX = 4'(LOG2N_MAX);
  localparam logic [CW:0] ONE  = (CW+1)'(1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                state, state_nx;
  logic [3:0]            n_lat;
  logic [3:0]            n_clamp;
  logic [CW-1:0]         cnt;
  logic [CW:0]           last_idx;
  logic signed [AW-1:0]  acc;
  logic signed [RES-1:0] run_min;
  logic signed [RES-1:0] run_max;
  logic                  take;
  logic                  last;
  logic                  arm;

  assign n_clamp  = (log2n > NMAX) ? NMAX : log2n;
  assign last_idx = (ONE << n_lat) - ONE;
  assign take     = (state == ACC) && in_en;
  assign last     = ({1'b0, cnt} == last_idx);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // arm marks every window start: from IDLE and on a continuous re-arm out of DONE
  always_comb begin
    state_nx = state;
    arm      = 1'b0;
    case (state)
      IDLE: begin
        if (start || cont) begin
          state_nx = ACC;
          arm      = 1'b1;
        end
      end
      ACC: begin
        if (take && last) state_nx = DONE;
      end
      DONE: begin
        if (cont) begin
          state_nx = ACC;
          arm      = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat   <= '0;
      cnt     <= '0;
      acc     <= '0;
      run_min <= '0;
      run_max <= '0;
      mean    <= '0;
      min     <= '0;
      max     <= '0;
      valid   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (arm) begin
        n_lat <= n_clamp;
        cnt   <= '0;
        acc   <= '0;
      end else if (take) begin
        acc <= acc + AW'(in_dat);
        cnt <= cnt + CW'(1);
        if (cnt == '0) begin
          run_min <= in_dat;
          run_max <= in_dat;
        end else begin
          if (in_dat < run_min) run_min <= in_dat;
          if (in_dat > run_max) run_max <= in_dat;
        end
      end
      // arithmetic shift floors toward -inf for negative sums
      if (state == DONE) begin
        mean  <= RES'(acc >>> n_lat);
        min   <= run_min;
        max   <= run_max;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stats_window.sv
// tb/tb_stats_window.sv - directed self-checking bench for stats_window
module tb_stats_window;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [13:0] in_dat;
  logic              in_en;
  logic              start;
  logic              cont;
  logic [3:0]        log2n;
  logic signed [13:0] mean;
  logic signed [13:0] min;
  logic signed [13:0] max;
  logic              valid;
  logic              busy;

  int n_run  = 0;
  int n_fail = 0;

  int w_mean[3] = '{4, 13, 22};
  int w_min[3]  = '{1, 10, 19};
  int w_max[3]  = '{8, 17, 26};

  stats_window #(.RES(14), .LOG2N_MAX(13)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_en(in_en), .start(start),
    .cont(cont), .log2n(log2n), .mean(mean), .min(min), .max(max),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int m, input int mn, input int mx);
    chk({tag, "_valid"}, int'(valid), 1);
    chk({tag, "_mean"}, int'(mean), m);
    chk({tag, "_min"}, int'(min), mn);
    chk({tag, "_max"}, int'(max), mx);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [3:0] l, input logic c);
    log2n = l;
    cont  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int v);
    in_dat = 14'(v);
    in_en  = 1'b1;
    tick();
    in_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_dat = '0; in_en = 1'b0; start = 1'b0; cont = 1'b0; log2n = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_mean", int'(mean), 0);
    chk("rst_min", int'(min), 0);
    chk("rst_max", int'(max), 0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: basic window of 4
    arm(4'd2, 1'b0);
    feed(10); feed(20); feed(30); feed(41);
    chk("t1_busy_done", int'(busy), 1);
    chk("t1_valid_early", int'(valid), 0);
    tick();
    chk_res("t1", 25, 10, 41);
    chk("t1_busy_idle", int'(busy), 0);
    tick();
    chk("t1_valid_pulse", int'(valid), 0);
    chk("t1_mean_hold", int'(mean), 25);

    // 2: negative mean floors toward -inf
    arm(4'd1, 1'b0);
    feed(-3); feed(-4);
    tick();
    chk_res("t2", -4, -4, -3);

    // 3: largest window at both extremes, continuous then released
    arm(4'd13, 1'b1);
    repeat (8192) feed(8191);
    tick();
    chk_res("t3a", 8191, 8191, 8191);
    chk("t3a_busy", int'(busy), 1);
    for (int i = 0; i < 8192; i++) begin
      if (i == 100) cont = 1'b0;
      feed(-8192);
    end
    tick();
    chk_res("t3b", -8192, -8192, -8192);
    chk("t3b_busy", int'(busy), 0);

    // 4: continuous ramp, in_en held high, one result every 9 clocks
    log2n = 4'd3; cont = 1'b1; in_en = 1'b1; in_dat = '0;
    tick();
    for (int i = 1; i <= 27; i++) begin
      in_dat = 14'(i);
      tick();
      if (i % 9 == 0) chk_res($sformatf("t4_w%0d", i / 9), w_mean[i/9-1], w_min[i/9-1], w_max[i/9-1]);
      else            chk($sformatf("t4_novalid_%0d", i), int'(valid), 0);
    end
    in_en = 1'b0; cont = 1'b0;

    // 5: reset mid-window discards partial data
    rst = 1'b1; tick(); rst = 1'b0;
    arm(4'd2, 1'b0);
    feed(7); feed(9);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_mean", int'(mean), 0);
    chk("t5_rst_max", int'(max), 0);
    @(posedge clk); #1; rst = 1'b0;
    arm(4'd2, 1'b0);
    repeat (4) feed(5);
    tick();
    chk_res("t5", 5, 5, 5);

    // 6a: single-sample window
    arm(4'd0, 1'b0);
    feed(-77);
    tick();
    chk_res("t6a", -77, -77, -77);

    // 6b: start and log2n changes mid-window are ignored
    arm(4'd2, 1'b0);
    feed(100);
    start = 1'b1; log2n = 4'd0;
    feed(200);
    chk("t6b_novalid", int'(valid), 0);
    chk("t6b_busy", int'(busy), 1);
    feed(-50);
    start = 1'b0;
    feed(6);
    chk("t6b_valid_early", int'(valid), 0);
    tick();
    chk_res("t6b", 64, -50, 200);
    tick();
    chk("t6b_idle", int'(busy), 0);
    chk("t6b_pulse", int'(valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
